// File: rtl/alu_sequencer.sv
// Small ALU front end: single-cycle add/sub/logic/compare operations plus an
// optional iterative shift-and-add multiplier that holds busy while it runs.
module alu_sequencer #(
  parameter int WIDTH  = 32,
  parameter int MUL_EN = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       alu_op,
  input  logic [5:0]       func,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             busy,
  output logic             done,
  output logic             illegal
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  localparam logic [1:0] OP_MTYPE = 2'b00;
  localparam logic [1:0] OP_BTYPE = 2'b01;
  localparam logic [1:0] OP_RTYPE = 2'b10;

  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_SLT  = 6'b101010;
  localparam logic [5:0] FN_MULT = 6'b011000;

  typedef enum logic {
    IDLE,
    MULT
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] acc;
  logic [CNT_W-1:0] cnt;

  logic [WIDTH-1:0] comb_res;
  logic             comb_illegal;
  logic             comb_mult;
  logic [WIDTH-1:0] acc_step;

  assign busy = (state == MULT);

  // Decode of the single-cycle operations; JTYPE and illegal encodings fall
  // through with a zero result.
  always_comb begin
    comb_res     = '0;
    comb_illegal = 1'b0;
    comb_mult    = 1'b0;
    case (alu_op)
      OP_MTYPE: comb_res = a + b;
      OP_BTYPE: comb_res = a - b;
      OP_RTYPE: begin
        case (func)
          FN_ADD:  comb_res = a + b;
          FN_SUB:  comb_res = a - b;
          FN_AND:  comb_res = a & b;
          FN_OR:   comb_res = a | b;
          FN_SLT:  comb_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
          FN_MULT: begin
            if (MUL_EN != 0) comb_mult = 1'b1;
            else             comb_illegal = 1'b1;
          end
          default: comb_illegal = 1'b1;
        endcase
      end
      default: comb_res = '0;
    endcase
  end

  assign acc_step = mplier[0] ? (acc + mcand) : acc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      result  <= '0;
      zero    <= 1'b1;
      done    <= 1'b0;
      illegal <= 1'b0;
      mcand   <= '0;
      mplier  <= '0;
      acc     <= '0;
      cnt     <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (comb_mult) begin
              mcand  <= a;
              mplier <= b;
              acc    <= '0;
              cnt    <= '0;
              state  <= MULT;
            end else begin
              result  <= comb_res;
              zero    <= (comb_res == '0);
              illegal <= comb_illegal;
              done    <= 1'b1;
            end
          end
        end
        MULT: begin
          acc    <= acc_step;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 1'b1;
          // The WIDTH-th iteration folds its partial product straight into the result.
          if (cnt == CNT_LAST) begin
            result  <= acc_step;
            zero    <= (acc_step == '0);
            illegal <= 1'b0;
            done    <= 1'b1;
            cnt     <= '0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: table of single-cycle vectors plus
// hand-written multiplier, busy-ignore and reset-abort sequences.
module tb_alu_sequencer;

  localparam int W = 32;

  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_SLT  = 6'b101010;
  localparam logic [5:0] FN_MULT = 6'b011000;

  logic         clk;
  logic         rst;
  logic         start;
  logic [1:0]   alu_op;
  logic [5:0]   func;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [W-1:0] result;
  logic         zero;
  logic         busy;
  logic         done;
  logic         illegal;

  int checks;
  int failures;

  typedef struct {
    logic [1:0]   op;
    logic [5:0]   fn;
    logic [W-1:0] va;
    logic [W-1:0] vb;
    logic [W-1:0] exp_res;
    logic         exp_zero;
    logic         exp_ill;
  } vec_t;

  vec_t vecs[13];

  alu_sequencer #(.WIDTH(W), .MUL_EN(1)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .alu_op  (alu_op),
    .func    (func),
    .a       (a),
    .b       (b),
    .result  (result),
    .zero    (zero),
    .busy    (busy),
    .done    (done),
    .illegal (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkField(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic checkOutput(input string name, input logic [W-1:0] exp_res, input logic exp_zero,
                             input logic exp_done, input logic exp_ill, input logic exp_busy);
    checkField({name, ".result"},  64'(result),  64'(exp_res));
    checkField({name, ".zero"},    64'(zero),    64'(exp_zero));
    checkField({name, ".done"},    64'(done),    64'(exp_done));
    checkField({name, ".illegal"}, 64'(illegal), 64'(exp_ill));
    checkField({name, ".busy"},    64'(busy),    64'(exp_busy));
  endtask

  // Drive a request at the falling edge, then sample just after the next rising edge.
  task automatic applyStimulus(input logic st, input logic [1:0] op, input logic [5:0] fn,
                               input logic [W-1:0] va, input logic [W-1:0] vb);
    @(negedge clk);
    start  = st;
    alu_op = op;
    func   = fn;
    a      = va;
    b      = vb;
    @(posedge clk);
    #1;
  endtask

  task automatic runMult(input string name, input logic [W-1:0] va, input logic [W-1:0] vb,
                         input logic [W-1:0] exp_res, input logic [W-1:0] prev_res);
    int n;
    logic [W-1:0] dummy;
    dummy = '0;
    applyStimulus(1'b1, 2'b10, FN_MULT, va, vb);
    checkOutput({name, ".accept"}, prev_res, (prev_res == dummy), 1'b0, 1'b0, 1'b1);
    n = 0;
    @(negedge clk);
    start = 1'b0;
    while (n < 40) begin
      @(posedge clk);
      #1;
      n++;
      if (done) break;
    end
    checkField({name, ".latency"}, 64'(n), 64'(W));
    checkOutput({name, ".done"}, exp_res, (exp_res == dummy), 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    start    = 1'b0;
    alu_op   = 2'b00;
    func     = 6'b000000;
    a        = '0;
    b        = '0;
    rst      = 1'b1;

    vecs[0]  = '{2'b10, FN_ADD, 32'd5,          32'd7,          32'd12,         1'b0, 1'b0};
    vecs[1]  = '{2'b01, 6'd0,   32'd9,          32'd9,          32'd0,          1'b1, 1'b0};
    vecs[2]  = '{2'b10, FN_SLT, 32'hFFFFFFFF,   32'd1,          32'd1,          1'b0, 1'b0};
    vecs[3]  = '{2'b10, FN_SLT, 32'd1,          32'hFFFFFFFF,   32'd0,          1'b1, 1'b0};
    vecs[4]  = '{2'b00, 6'd0,   32'hFFFFFFFF,   32'd1,          32'd0,          1'b1, 1'b0};
    vecs[5]  = '{2'b01, 6'd0,   32'd0,          32'd1,          32'hFFFFFFFF,   1'b0, 1'b0};
    vecs[6]  = '{2'b10, FN_AND, 32'hF0F0F0F0,   32'h0FF00FF0,   32'h00F000F0,   1'b0, 1'b0};
    vecs[7]  = '{2'b10, FN_OR,  32'h12340000,   32'h00005678,   32'h12345678,   1'b0, 1'b0};
    vecs[8]  = '{2'b10, FN_SUB, 32'd100,        32'd58,         32'd42,         1'b0, 1'b0};
    vecs[9]  = '{2'b11, FN_ADD, 32'd3,          32'd4,          32'd0,          1'b1, 1'b0};
    vecs[10] = '{2'b10, 6'b000111, 32'd3,       32'd4,          32'd0,          1'b1, 1'b1};
    vecs[11] = '{2'b10, FN_ADD, 32'd1,          32'd2,          32'd3,          1'b0, 1'b0};
    vecs[12] = '{2'b10, FN_SLT, 32'h80000000,   32'h7FFFFFFF,   32'd1,          1'b0, 1'b0};

    #2;
    checkOutput("reset", 32'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    // Consecutive starts: every vector must produce its own done pulse.
    for (int i = 0; i < 13; i++) begin
      applyStimulus(1'b1, vecs[i].op, vecs[i].fn, vecs[i].va, vecs[i].vb);
      checkOutput($sformatf("vec%0d", i), vecs[i].exp_res, vecs[i].exp_zero, 1'b1, vecs[i].exp_ill, 1'b0);
    end

    applyStimulus(1'b0, 2'b10, FN_ADD, 32'd8, 32'd8);
    checkOutput("idle_hold", 32'd1, 1'b0, 1'b0, 1'b0, 1'b0);

    // Multiply with start held high the whole time: ignored while busy,
    // including on the completion edge, then accepted on the following edge.
    applyStimulus(1'b1, 2'b10, FN_MULT, 32'h00010000, 32'h00030003);
    checkOutput("mult_accept", 32'd1, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int k = 1; k < W; k++) begin
      applyStimulus(1'b1, 2'b10, FN_ADD, 32'd5, 32'd5);
      if (done !== 1'b0 || busy !== 1'b1 || result !== 32'd1) begin
        checkOutput($sformatf("mult_busy%0d", k), 32'd1, 1'b0, 1'b0, 1'b0, 1'b1);
      end
    end
    checkField("mult_busy_last", 64'(busy), 64'(1));
    applyStimulus(1'b1, 2'b10, FN_ADD, 32'd5, 32'd5);
    checkOutput("mult_done", 32'h00030000, 1'b0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 2'b10, FN_ADD, 32'd5, 32'd5);
    checkOutput("post_mult_add", 32'd10, 1'b0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    start = 1'b0;

    runMult("mult_7x6", 32'd7, 32'd6, 32'd42, 32'd10);
    runMult("mult_max", 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1, 32'd42);
    runMult("mult_zero", 32'h12345678, 32'd0, 32'd0, 32'd1);

    // Abort a multiply mid-flight with an asynchronous reset.
    applyStimulus(1'b1, 2'b00, 6'd0, 32'd20, 32'd7);
    checkOutput("pre_abort", 32'd27, 1'b0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 2'b10, FN_MULT, 32'd3, 32'd5);
    checkOutput("abort_accept", 32'd27, 1'b0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 2'b10, FN_MULT, 32'd3, 32'd5);
    for (int k = 2; k < 10; k++) applyStimulus(1'b0, 2'b10, FN_ADD, 32'd0, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("abort_reset", 32'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    checkOutput("abort_hold", 32'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    start  = 1'b1;
    alu_op = 2'b10;
    func   = FN_ADD;
    a      = 32'd1;
    b      = 32'd1;
    @(posedge clk);
    #1;
    checkOutput("after_reset_add", 32'd2, 1'b0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < W + 4; k++) begin
      @(posedge clk);
      #1;
      if (done !== 1'b0 || busy !== 1'b0) begin
        checkOutput($sformatf("no_stray_done%0d", k), 32'd2, 1'b0, 1'b0, 1'b0, 1'b0);
      end
    end
    checkOutput("quiet_end", 32'd2, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 Parameter WIDTH, default 32, datapath width in bits (legal range 4..64).
REQ-002 Parameter MUL_EN, default 1, enables iterative MULT; 0 makes MULT illegal.
REQ-003 clk  input  1  single clock, all state on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 start  input  1  request; accepted only when busy=0.
REQ-006 alu_op  input  2  class: 00 MTYPE, 01 BTYPE, 10 RTYPE, 11 JTYPE.
REQ-007 func  input  6  RTYPE function: ADD 100000, SUB 100010, AND 100100, OR 100101, SLT 101010, MULT 011000.
REQ-008 a, b  input  WIDTH  operands, sampled at the accepting edge only.
REQ-009 result  output  WIDTH  registered result, held until next done.
REQ-010 zero  output  1  registered, 1 when result==0.
REQ-011 busy  output  1  high while a MULT is iterating.
REQ-012 done  output  1  one-cycle pulse, result/zero/illegal valid.
REQ-013 illegal  output  1  registered with done; 1 for undecoded RTYPE func.

Function
REQ-014 FSM states IDLE, MULT; busy = (state==MULT).
REQ-015 Acceptance: rising edge with start=1 and busy=0; start with busy=1 ignored, no queueing.
REQ-016 MTYPE -> a+b; BTYPE -> a-b; RTYPE ADD/SUB/AND/OR per func; SLT -> signed a<b gives 1 else 0, zero-extended.
REQ-017 Add/sub modulo 2^WIDTH, carry/overflow discarded.
REQ-018 Single-cycle class (all except MULT): result, zero, illegal updated and done=1 at the accepting edge; state stays IDLE; back-to-back starts every cycle give done every cycle.
REQ-019 JTYPE -> result 0, zero 1, illegal 0, done as single-cycle.
REQ-020 Undecoded RTYPE func (or MULT with MUL_EN=0) -> result 0, zero 1, illegal 1, done as single-cycle.
REQ-021 MULT accept: load multiplicand=a, multiplier=b, accumulator=0, counter=0, enter MULT; done=0.
REQ-022 Each MULT cycle: if multiplier LSB=1 add multiplicand to accumulator; shift multiplicand left 1, multiplier right 1; counter+1.
REQ-023 At edge where counter reaches WIDTH-1 (WIDTH-th iteration): result = low WIDTH bits of unsigned a*b, zero updated, illegal 0, done=1, state -> IDLE.
REQ-024 MULT latency: done asserted WIDTH edges after accepting edge; busy high for exactly WIDTH cycles.
REQ-025 start asserted in the cycle done pulses for MULT completion is ignored (busy still 1 at that edge).
REQ-026 done=0 on every edge not listed above; result/zero/illegal unchanged on such edges.
REQ-027 counter width ceil(log2(WIDTH)) bits, no wrap during an operation.

Reset
REQ-028 rst=1 forces immediately: state IDLE, result 0, zero 1, busy 0, done 0, illegal 0, counter 0, accumulator 0.
REQ-029 rst during MULT aborts operation; no done pulse for it; start accepted first edge after rst falls.

Verification
REQ-030 WIDTH=32, alu_op=10, func=ADD, a=5, b=7, start 1 cycle -> next edge result=12, zero=0, done=1 for one cycle.
REQ-031 alu_op=01, a=9, b=9 -> result=0, zero=1, done=1; then SLT a=FFFFFFFF, b=1 -> result=1.
REQ-032 MULT a=0x10000, b=0x30003 -> busy=1 for 32 cycles, start pulses during busy ignored, done at edge 32 with result=0x00030000 (low 32 bits of 0x3_0003_0000).
REQ-033 func=000111 -> result 0, illegal=1, done=1; following ADD -> illegal=0.
REQ-034 MULT accepted, rst asserted at cycle 10 -> outputs at reset values, no done; ADD 1+1 after release -> result=2.
REQ-035 Back-to-back: four single-cycle starts on consecutive cycles -> four consecutive done pulses with matching results.
